wr_circ_buf_engine: RTL and testbench
=====================================

Name: wr_circ_buf_engine

Overview:
- Write-side counterpart of the circular-buffer read path. It accepts a write request (flowid, offset, size) and a MAC-width data stream from a source.
- It writes the stream into the flow's circular buffer in DRAM using NoC0 write-request header and data flits. It waits for the DRAM write acknowledgement, then signals completion to the source.
- A write that crosses the end of the buffer is split into two NoC transactions.

Parameters:
- BUF_PTR_W, -1, log2 of per-flow buffer size in bytes; must be overridden.
- SRC_X, 0, NoC X coordinate of this tile.
- SRC_Y, 0, NoC Y coordinate of this tile.
- DST_DRAM_X, 0, NoC X coordinate of the DRAM controller.
- DST_DRAM_Y, 0, NoC Y coordinate of the DRAM controller.
- FBITS, 0, fbits value placed in the header.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wr_buf_noc0_val  out  1  outgoing NoC flit valid.
- wr_buf_noc0_data  out  NOC_DATA_WIDTH  outgoing flit (header or data).
- noc0_wr_buf_rdy  in  1  NoC accepts outgoing flit.
- noc0_wr_buf_val  in  1  incoming response flit valid.
- noc0_wr_buf_data  in  NOC_DATA_WIDTH  incoming response flit.
- wr_buf_noc0_rdy  out  1  block accepts response flit.
- src_wr_buf_req_val  in  1  request valid.
- src_wr_buf_req_flowid  in  FLOW_ID_W  flow selecting the buffer.
- src_wr_buf_req_offset  in  BUF_PTR_W  byte offset in the buffer.
- src_wr_buf_req_size  in  MSG_DATA_SIZE_WIDTH  bytes to write, 1 or more.
- wr_buf_src_req_rdy  out  1  request accepted.
- src_wr_buf_data_val  in  1  data beat valid.
- src_wr_buf_data  in  MAC_INTERFACE_W  data beat, MSB-first bytes.
- src_wr_buf_data_last  in  1  final beat.
- src_wr_buf_data_padbytes  in  MAC_PADBYTES_W  invalid trailing bytes in the last beat.
- wr_buf_src_data_rdy  out  1  beat accepted.
- wr_buf_src_done_val  out  1  write complete.
- src_wr_buf_done_rdy  in  1  source takes completion.

Behaviour:
- Requirements on the inputs:
  - MAC_INTERFACE_W equals NOC_DATA_WIDTH.
  - The offset is a multiple of MAC_INTERFACE_BYTES.
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - All val outputs and rdy outputs are 0.
  - Registers are cleared.
  - wr_buf_noc0_data is 0.
- Address and split arithmetic:
  - addr = {flowid, offset}, zero-extended to the address width.
  - seg0_size = min(size, 2^BUF_PTR_W - offset), computed at BUF_PTR_W+1 bits.
  - seg1_size = size - seg0_size. If seg1_size != 0, seg1 is written at {flowid, 0}.
  - Flits per segment = ceil(seg_size / MAC_INTERFACE_BYTES).
- FSM, one transaction in flight:
  - IDLE:
    - rdy=1 on the request port.
    - On req_val, latch flowid, offset, size and seg0/seg1 sizes, then go to HDR.
  - HDR:
    - Drive the header flit: DRAM write type, dst DRAM_X/Y, src X/Y, FBITS, addr, seg_size, data flit count.
    - When val&rdy, load the beat counter and go to DATA.
  - DATA:
    - wr_buf_noc0_val = src_data_val.
    - wr_buf_src_data_rdy = noc0_wr_buf_rdy.
    - Data passes through combinationally, zero added latency.
    - Padbytes are masked to zero on the final beat of the request.
    - The counter decrements on each transfer. At zero, go to WAIT_RESP.
  - WAIT_RESP:
    - wr_buf_noc0_rdy=1.
    - On a response flit, go to HDR if seg1 is pending (seg1 becomes the active segment), otherwise go to DONE.
  - DONE:
    - done_val=1.
    - On done_rdy, go to IDLE.
- Boundary conditions:
  - Split point: the split is always on a flit boundary, so beat k of the source maps to seg1 beat k - seg0_flits.
  - Exact fit, offset + size = 2^BUF_PTR_W: no split.
  - src last asserted before the expected count, or count reached without last: flag a sticky protocol error (sim assertion). The FSM follows the count.
  - A response flit arriving outside WAIT_RESP is not accepted (rdy=0).
  - Back-to-back requests: the next request is accepted in the cycle after the DONE handshake.
- Reset mid-operation aborts the transaction immediately.
  - A partial NoC packet may result; system reset covers the NoC.

Optional Feature:
- Macro: WR_CIRC_BUF_POSTED_EN.
- Defined:
  - Writes are posted. WAIT_RESP is removed: DATA goes to HDR (when seg1 is pending) or to DONE.
  - wr_buf_noc0_rdy is tied to 1 and response flits are dropped.
  - No outstanding-write counting.
- Undefined: the acknowledged behaviour above.

Decomposition:
- noc_struct_pkg holds:
  - the DRAM write header struct (msg type, coords, fbits, addr, size, flit count), shared with the read path;
  - a wr_circ_buf_state_e enum;
  - the localparam for MAC_INTERFACE_BYTES.
- Sub-module wr_circ_buf_seg_calc: combinational address/size/flit-count computation from a request. It is instantiated once and fed by the latched registers.

Test Plan:
- BUF_PTR_W=12, 64-byte beats; offset=0x040, size=128 -> one header with addr {flow, 0x040} and size 128, 2 data flits, 1 response, done_val pulses once.
- offset=0xFC0, size=192 -> seg0 header (0xFC0, 64 B, 1 flit), response, then seg1 header (0x000, 128 B, 2 flits), response, done.
- offset=0xF80, size=128 -> exact fit, a single transaction, no second header.
- size=70, padbytes=58 on the last beat -> 2 flits, the last has its low 58 bytes zero, header size 70.
- Random deassertion of noc0_wr_buf_rdy and src data_val -> flit order and data intact, no duplicate or lost beats, response gated until WAIT_RESP.
- rst low during DATA -> all outputs 0 within the reset assertion. After release the block is IDLE with req_rdy=1, and a new request completes normally.

Source files
------------

// File: rtl/noc_struct_pkg.sv
// rtl/noc_struct_pkg.sv - shared NoC widths, DRAM write header layout and write-engine states
//
// Purpose: common definitions for the circular-buffer read and write paths.
//   - NoC/MAC widths: one MAC beat is exactly one NoC flit.
//   - dram_hdr_t: DRAM request header, zero-extended into the low bits of a flit.
//   - wr_circ_buf_state_e: write-engine FSM encoding.
// Ports: none (package).
package noc_struct_pkg;

  localparam int NOC_DATA_WIDTH      = 512;
  localparam int MAC_INTERFACE_W     = NOC_DATA_WIDTH;
  localparam int MAC_INTERFACE_BYTES = MAC_INTERFACE_W / 8;
  localparam int MAC_BYTES_LOG2      = $clog2(MAC_INTERFACE_BYTES);
  localparam int MAC_PADBYTES_W      = MAC_BYTES_LOG2;
  localparam int FLOW_ID_W           = 4;
  localparam int MSG_DATA_SIZE_WIDTH = 16;
  localparam int DRAM_ADDR_W         = 40;
  localparam int NOC_COORD_W         = 8;
  localparam int NOC_FBITS_W         = 4;
  localparam int MSG_TYPE_W          = 8;
  localparam int NOC_FLIT_CNT_W      = 16;

  localparam logic [MSG_TYPE_W-1:0] MSG_DRAM_RD = 8'h12;
  localparam logic [MSG_TYPE_W-1:0] MSG_DRAM_WR = 8'h13;

  typedef struct packed {
    logic [MSG_TYPE_W-1:0]          msg_type;
    logic [NOC_COORD_W-1:0]         dst_x;
    logic [NOC_COORD_W-1:0]         dst_y;
    logic [NOC_COORD_W-1:0]         src_x;
    logic [NOC_COORD_W-1:0]         src_y;
    logic [NOC_FBITS_W-1:0]         fbits;
    logic [DRAM_ADDR_W-1:0]         addr;
    logic [MSG_DATA_SIZE_WIDTH-1:0] size;
    logic [NOC_FLIT_CNT_W-1:0]      flit_cnt;
  } dram_hdr_t;

  localparam int DRAM_HDR_W = $bits(dram_hdr_t);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_DATA      = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_DONE      = 3'd4
  } wr_circ_buf_state_e;

  // Header occupies the low bits of the flit; the rest is zero.
  function automatic logic [NOC_DATA_WIDTH-1:0] hdr_to_flit(input dram_hdr_t h);
    return {{(NOC_DATA_WIDTH - DRAM_HDR_W){1'b0}}, h};
  endfunction

endpackage

// File: rtl/wr_circ_buf_seg_calc.sv
// rtl/wr_circ_buf_seg_calc.sv - split a circular-buffer write into segments and size the active one
//
// Purpose: purely combinational. seg0 runs from offset up to the end of the
//   buffer (or the whole write if it fits); seg1 is the remainder starting at
//   offset 0 of the same flow.
// Ports:
//   flowid, offset, size   latched request
//   seg_sel                0 = seg0 active, 1 = seg1 active
//   seg_addr               {flowid, seg offset} zero-extended
//   seg_size               bytes in the active segment
//   seg_flits              data flits in the active segment (rounded up)
//   seg1_pending           the request wraps, seg1 is non-empty
module wr_circ_buf_seg_calc
  import noc_struct_pkg::*;
#(
  parameter int PTR_W = 12
) (
  input  logic [FLOW_ID_W-1:0]           flowid,
  input  logic [PTR_W-1:0]               offset,
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] size,
  input  logic                           seg_sel,
  output logic [DRAM_ADDR_W-1:0]         seg_addr,
  output logic [MSG_DATA_SIZE_WIDTH-1:0] seg_size,
  output logic [NOC_FLIT_CNT_W-1:0]      seg_flits,
  output logic                           seg1_pending
);

  // Common width wide enough for both the room-to-end and the request size.
  localparam int CW = ((PTR_W + 1) > MSG_DATA_SIZE_WIDTH) ? (PTR_W + 1) : MSG_DATA_SIZE_WIDTH;

  logic [PTR_W:0]   room;
  logic [CW-1:0]    room_x;
  logic [CW-1:0]    size_x;
  logic [CW-1:0]    seg0_x;
  logic [CW-1:0]    seg1_x;
  logic [CW-1:0]    act_x;
  logic [CW:0]      round_up;
  logic [PTR_W-1:0] seg_off;

  always_comb begin
    room         = {1'b1, {PTR_W{1'b0}}} - {1'b0, offset};
    room_x       = CW'(room);
    size_x       = CW'(size);
    seg0_x       = (size_x < room_x) ? size_x : room_x;
    seg1_x       = size_x - seg0_x;
    seg1_pending = (seg1_x != '0);
    act_x        = seg_sel ? seg1_x : seg0_x;
    seg_size     = MSG_DATA_SIZE_WIDTH'(act_x);
    round_up     = {1'b0, act_x} + (CW + 1)'(MAC_INTERFACE_BYTES - 1);
    seg_flits    = NOC_FLIT_CNT_W'(round_up >> MAC_BYTES_LOG2);
    seg_off      = seg_sel ? {PTR_W{1'b0}} : offset;
    seg_addr     = DRAM_ADDR_W'({flowid, seg_off});
  end

endmodule

// File: rtl/wr_circ_buf_engine.sv
// rtl/wr_circ_buf_engine.sv - write a source data stream into a flow's circular DRAM buffer over NoC0
//
// Purpose: accepts (flowid, offset, size) plus a MAC-width data stream, emits a
//   DRAM write header and data flits per segment (two segments when the write
//   wraps past the end of the buffer), waits for each DRAM ack, then raises done.
// Configuration: define WR_CIRC_BUF_POSTED_EN for posted writes (no ack wait,
//   response flits are accepted and dropped).
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   wr_buf_noc0_val/data, noc0_wr_buf_rdy      outgoing NoC0 flits
//   noc0_wr_buf_val/data, wr_buf_noc0_rdy      incoming DRAM write acks
//   src_wr_buf_req_*, wr_buf_src_req_rdy       write request
//   src_wr_buf_data*, wr_buf_src_data_rdy      source data beats (MSB-first bytes)
//   wr_buf_src_done_val, src_wr_buf_done_rdy   completion handshake
module wr_circ_buf_engine
  import noc_struct_pkg::*;
#(
  parameter int BUF_PTR_W  = -1,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0,
  parameter int DST_DRAM_X = 0,
  parameter int DST_DRAM_Y = 0,
  parameter int FBITS      = 0,
  localparam int PTR_W     = (BUF_PTR_W > 0) ? BUF_PTR_W : 1
) (
  input  logic                           clk,
  input  logic                           rst,

  output logic                           wr_buf_noc0_val,
  output logic [NOC_DATA_WIDTH-1:0]      wr_buf_noc0_data,
  input  logic                           noc0_wr_buf_rdy,

  input  logic                           noc0_wr_buf_val,
  input  logic [NOC_DATA_WIDTH-1:0]      noc0_wr_buf_data,
  output logic                           wr_buf_noc0_rdy,

  input  logic                           src_wr_buf_req_val,
  input  logic [FLOW_ID_W-1:0]           src_wr_buf_req_flowid,
  input  logic [PTR_W-1:0]               src_wr_buf_req_offset,
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] src_wr_buf_req_size,
  output logic                           wr_buf_src_req_rdy,

  input  logic                           src_wr_buf_data_val,
  input  logic [MAC_INTERFACE_W-1:0]     src_wr_buf_data,
  input  logic                           src_wr_buf_data_last,
  input  logic [MAC_PADBYTES_W-1:0]      src_wr_buf_data_padbytes,
  output logic                           wr_buf_src_data_rdy,

  output logic                           wr_buf_src_done_val,
  input  logic                           src_wr_buf_done_rdy
);

  wr_circ_buf_state_e state_q, state_d;

  logic [FLOW_ID_W-1:0]           flowid_q, flowid_d;
  logic [PTR_W-1:0]               offset_q, offset_d;
  logic [MSG_DATA_SIZE_WIDTH-1:0] size_q, size_d;
  logic                           seg_sel_q, seg_sel_d;
  logic [NOC_FLIT_CNT_W-1:0]      cnt_q, cnt_d;
  logic                           proto_err_q, proto_err_d;
  logic                           req_rdy_q, req_rdy_d;
  logic                           resp_rdy_q, resp_rdy_d;
  logic                           done_val_q, done_val_d;

  logic [DRAM_ADDR_W-1:0]         seg_addr;
  logic [MSG_DATA_SIZE_WIDTH-1:0] seg_size;
  logic [NOC_FLIT_CNT_W-1:0]      seg_flits;
  logic                           seg1_pending;

  logic                           seg1_more;
  logic                           req_final_beat;
  logic                           data_xfer;
  logic [NOC_DATA_WIDTH-1:0]      keep_mask;
  dram_hdr_t                      hdr;
  logic                           noc_val;
  logic [NOC_DATA_WIDTH-1:0]      noc_data;
  logic                           src_data_rdy;
  logic                           resp_unused;

  // Response payload carries nothing the engine needs.
  assign resp_unused = ^{noc0_wr_buf_val, noc0_wr_buf_data};

  wr_circ_buf_seg_calc #(
    .PTR_W (PTR_W)
  ) u_seg_calc (
    .flowid       (flowid_q),
    .offset       (offset_q),
    .size         (size_q),
    .seg_sel      (seg_sel_q),
    .seg_addr     (seg_addr),
    .seg_size     (seg_size),
    .seg_flits    (seg_flits),
    .seg1_pending (seg1_pending)
  );

  always_comb begin
    state_d      = state_q;
    flowid_d     = flowid_q;
    offset_d     = offset_q;
    size_d       = size_q;
    seg_sel_d    = seg_sel_q;
    cnt_d        = cnt_q;
    proto_err_d  = proto_err_q;
    noc_val      = 1'b0;
    noc_data     = '0;
    src_data_rdy = 1'b0;

    seg1_more      = !seg_sel_q && seg1_pending;
    req_final_beat = (cnt_q == NOC_FLIT_CNT_W'(1)) && !seg1_more;
    data_xfer      = src_wr_buf_data_val && noc0_wr_buf_rdy;
    // Trailing pad bytes sit in the low end of the final beat.
    keep_mask      = req_final_beat ?
                     ({NOC_DATA_WIDTH{1'b1}} << {src_wr_buf_data_padbytes, 3'b000}) :
                     {NOC_DATA_WIDTH{1'b1}};

    hdr.msg_type = MSG_DRAM_WR;
    hdr.dst_x    = NOC_COORD_W'(DST_DRAM_X);
    hdr.dst_y    = NOC_COORD_W'(DST_DRAM_Y);
    hdr.src_x    = NOC_COORD_W'(SRC_X);
    hdr.src_y    = NOC_COORD_W'(SRC_Y);
    hdr.fbits    = NOC_FBITS_W'(FBITS);
    hdr.addr     = seg_addr;
    hdr.size     = seg_size;
    hdr.flit_cnt = seg_flits;

    case (state_q)
      ST_IDLE: begin
        if (req_rdy_q && src_wr_buf_req_val) begin
          flowid_d  = src_wr_buf_req_flowid;
          offset_d  = src_wr_buf_req_offset;
          size_d    = src_wr_buf_req_size;
          seg_sel_d = 1'b0;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        noc_val  = 1'b1;
        noc_data = hdr_to_flit(hdr);
        if (noc0_wr_buf_rdy) begin
          cnt_d   = seg_flits;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        noc_val      = src_wr_buf_data_val;
        noc_data     = src_wr_buf_data & keep_mask;
        src_data_rdy = noc0_wr_buf_rdy;
        if (data_xfer) begin
          cnt_d = cnt_q - NOC_FLIT_CNT_W'(1);
          // Source framing must agree with the size; the count still rules.
          if (src_wr_buf_data_last != req_final_beat) begin
            proto_err_d = 1'b1;
          end
          if (cnt_q == NOC_FLIT_CNT_W'(1)) begin
`ifdef WR_CIRC_BUF_POSTED_EN
            if (seg1_more) begin
              seg_sel_d = 1'b1;
              state_d   = ST_HDR;
            end else begin
              state_d   = ST_DONE;
            end
`else
            state_d = ST_WAIT_RESP;
`endif
          end
        end
      end
`ifndef WR_CIRC_BUF_POSTED_EN
      ST_WAIT_RESP: begin
        if (resp_rdy_q && noc0_wr_buf_val) begin
          if (seg1_more) begin
            seg_sel_d = 1'b1;
            state_d   = ST_HDR;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end
`endif
      ST_DONE: begin
        if (src_wr_buf_done_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_rdy_d  = (state_d == ST_IDLE);
    done_val_d = (state_d == ST_DONE);
`ifdef WR_CIRC_BUF_POSTED_EN
    resp_rdy_d = 1'b1;
`else
    resp_rdy_d = (state_d == ST_WAIT_RESP);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      flowid_q    <= '0;
      offset_q    <= '0;
      size_q      <= '0;
      seg_sel_q   <= 1'b0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
      req_rdy_q   <= 1'b0;
      resp_rdy_q  <= 1'b0;
      done_val_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flowid_q    <= flowid_d;
      offset_q    <= offset_d;
      size_q      <= size_d;
      seg_sel_q   <= seg_sel_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
      req_rdy_q   <= req_rdy_d;
      resp_rdy_q  <= resp_rdy_d;
      done_val_q  <= done_val_d;
    end
  end

  a_src_framing : assert property (@(posedge clk) disable iff (!rst)
    !(proto_err_d && !proto_err_q));

  assign wr_buf_noc0_val     = noc_val;
  assign wr_buf_noc0_data    = noc_data;
  assign wr_buf_src_data_rdy = src_data_rdy;
  assign wr_buf_src_req_rdy  = req_rdy_q;
  assign wr_buf_noc0_rdy     = resp_rdy_q;
  assign wr_buf_src_done_val = done_val_q;

endmodule

// File: tb/tb_wr_circ_buf_engine.sv
// tb/tb_wr_circ_buf_engine.sv - directed self-checking bench for wr_circ_buf_engine
module tb_wr_circ_buf_engine;
  import noc_struct_pkg::*;

  logic                           clk;
  logic                           rst;
  logic                           wr_buf_noc0_val;
  logic [NOC_DATA_WIDTH-1:0]      wr_buf_noc0_data;
  logic                           noc0_wr_buf_rdy;
  logic                           noc0_wr_buf_val;
  logic [NOC_DATA_WIDTH-1:0]      noc0_wr_buf_data;
  logic                           wr_buf_noc0_rdy;
  logic                           src_wr_buf_req_val;
  logic [FLOW_ID_W-1:0]           src_wr_buf_req_flowid;
  logic [11:0]                    src_wr_buf_req_offset;
  logic [MSG_DATA_SIZE_WIDTH-1:0] src_wr_buf_req_size;
  logic                           wr_buf_src_req_rdy;
  logic                           src_wr_buf_data_val;
  logic [MAC_INTERFACE_W-1:0]     src_wr_buf_data;
  logic                           src_wr_buf_data_last;
  logic [MAC_PADBYTES_W-1:0]      src_wr_buf_data_padbytes;
  logic                           wr_buf_src_data_rdy;
  logic                           wr_buf_src_done_val;
  logic                           src_wr_buf_done_rdy;

  int n_vec = 0;
  int n_err = 0;
  logic [NOC_DATA_WIDTH-1:0] exp_q[$];
  logic [NOC_DATA_WIDTH-1:0] got_q[$];

  wr_circ_buf_engine #(
    .BUF_PTR_W  (12),
    .SRC_X      (1),
    .SRC_Y      (2),
    .DST_DRAM_X (3),
    .DST_DRAM_Y (4),
    .FBITS      (5)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .wr_buf_noc0_val          (wr_buf_noc0_val),
    .wr_buf_noc0_data         (wr_buf_noc0_data),
    .noc0_wr_buf_rdy          (noc0_wr_buf_rdy),
    .noc0_wr_buf_val          (noc0_wr_buf_val),
    .noc0_wr_buf_data         (noc0_wr_buf_data),
    .wr_buf_noc0_rdy          (wr_buf_noc0_rdy),
    .src_wr_buf_req_val       (src_wr_buf_req_val),
    .src_wr_buf_req_flowid    (src_wr_buf_req_flowid),
    .src_wr_buf_req_offset    (src_wr_buf_req_offset),
    .src_wr_buf_req_size      (src_wr_buf_req_size),
    .wr_buf_src_req_rdy       (wr_buf_src_req_rdy),
    .src_wr_buf_data_val      (src_wr_buf_data_val),
    .src_wr_buf_data          (src_wr_buf_data),
    .src_wr_buf_data_last     (src_wr_buf_data_last),
    .src_wr_buf_data_padbytes (src_wr_buf_data_padbytes),
    .wr_buf_src_data_rdy      (wr_buf_src_data_rdy),
    .wr_buf_src_done_val      (wr_buf_src_done_val),
    .src_wr_buf_done_rdy      (src_wr_buf_done_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NOC_DATA_WIDTH-1:0] obs,
                       input logic [NOC_DATA_WIDTH-1:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [NOC_DATA_WIDTH-1:0] mk_hdr(input logic [39:0] addr,
                                                       input logic [15:0] size,
                                                       input logic [15:0] flits);
    dram_hdr_t h;
    h.msg_type = 8'h13;
    h.dst_x    = 8'd3;
    h.dst_y    = 8'd4;
    h.src_x    = 8'd1;
    h.src_y    = 8'd2;
    h.fbits    = 4'd5;
    h.addr     = addr;
    h.size     = size;
    h.flit_cnt = flits;
    return {{(NOC_DATA_WIDTH - $bits(dram_hdr_t)){1'b0}}, h};
  endfunction

  function automatic logic [NOC_DATA_WIDTH-1:0] beat_data(input logic [15:0] tag, input int k);
    logic [31:0] w;
    w = {tag, 8'(k), 8'hC3};
    return {16{w}};
  endfunction

  function automatic logic [NOC_DATA_WIDTH-1:0] pad_zero(input logic [NOC_DATA_WIDTH-1:0] d,
                                                         input int pad);
    for (int b = 0; b < pad; b++) d[b*8 +: 8] = 8'h00;
    return d;
  endfunction

  task automatic idle_inputs();
    src_wr_buf_req_val       = 1'b0;
    src_wr_buf_data_val      = 1'b0;
    src_wr_buf_data_last     = 1'b0;
    src_wr_buf_data_padbytes = '0;
    src_wr_buf_data          = '0;
    noc0_wr_buf_val          = 1'b0;
    noc0_wr_buf_data         = '0;
    noc0_wr_buf_rdy          = 1'b1;
    src_wr_buf_done_rdy      = 1'b0;
  endtask

  // Drives one request to completion and compares every accepted flit with exp_q.
  task automatic run_txn(input string name, input logic [3:0] flow, input logic [11:0] off,
                         input logic [15:0] size, input int pad, input int nbeats,
                         input bit stall, input logic [15:0] tag,
                         input int pkt0_len, input int pkt1_len);
    int beat_idx = 0;
    int pending  = 0;
    int n_flits  = 0;
    int n_resp   = 0;
    int n_done   = 0;
    int viol     = 0;
    bit hs_req = 0, hs_src = 0, hs_resp = 0, hs_done = 0, fin = 0;
    int nchk;
    got_q.delete();
    src_wr_buf_req_flowid = flow;
    src_wr_buf_req_offset = off;
    src_wr_buf_req_size   = size;
    src_wr_buf_req_val    = 1'b1;
    src_wr_buf_done_rdy   = 1'b1;
    for (int cyc = 0; cyc < 800 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (hs_req)  src_wr_buf_req_val = 1'b0;
      if (hs_src)  beat_idx++;
      if (hs_resp) pending--;
      if (hs_done) fin = 1;
      if (!fin) begin
        src_wr_buf_data_val      = (beat_idx < nbeats) && (!stall || $urandom_range(0, 2) != 0);
        src_wr_buf_data          = beat_data(tag, beat_idx);
        src_wr_buf_data_last     = (beat_idx == nbeats - 1);
        src_wr_buf_data_padbytes = (beat_idx == nbeats - 1) ? 6'(pad) : 6'd0;
        noc0_wr_buf_rdy          = !stall || ($urandom_range(0, 3) != 0);
        noc0_wr_buf_val          = (pending > 0) && (!stall || $urandom_range(0, 1) != 0);
        noc0_wr_buf_data         = {16{32'hACCE55ED}};
        #1;
        hs_req  = src_wr_buf_req_val && wr_buf_src_req_rdy;
        hs_src  = src_wr_buf_data_val && wr_buf_src_data_rdy;
        hs_resp = noc0_wr_buf_val && wr_buf_noc0_rdy;
        hs_done = wr_buf_src_done_val && src_wr_buf_done_rdy;
        if (wr_buf_noc0_rdy && pending == 0) viol++;
        if (wr_buf_noc0_val && noc0_wr_buf_rdy) begin
          got_q.push_back(wr_buf_noc0_data);
          n_flits++;
          if (n_flits == pkt0_len || (pkt1_len > 0 && n_flits == pkt0_len + pkt1_len)) pending++;
        end
        if (hs_resp) n_resp++;
        if (hs_done) n_done++;
      end
    end
    check({name, " finished"}, fin, 1);
    check({name, " req_rdy_after_done"}, wr_buf_src_req_rdy, 1);
    check({name, " done_count"}, n_done, 1);
    check({name, " resp_count"}, n_resp, (pkt1_len > 0) ? 2 : 1);
    check({name, " resp_rdy_outside_wait"}, viol, 0);
    check({name, " beats_taken"}, beat_idx, nbeats);
    check({name, " flit_count"}, got_q.size(), exp_q.size());
    nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) check($sformatf("%s flit%0d", name, i), got_q[i], exp_q[i]);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    src_wr_buf_req_flowid = '0;
    src_wr_buf_req_offset = '0;
    src_wr_buf_req_size   = '0;
    noc0_wr_buf_rdy       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst noc_val", wr_buf_noc0_val, 0);
    check("rst noc_data", wr_buf_noc0_data, '0);
    check("rst req_rdy", wr_buf_src_req_rdy, 0);
    check("rst resp_rdy", wr_buf_noc0_rdy, 0);
    check("rst done_val", wr_buf_src_done_val, 0);
    rst = 1'b1;
    noc0_wr_buf_rdy = 1'b1;
    @(posedge clk); #1;
    check("idle req_rdy", wr_buf_src_req_rdy, 1);
    noc0_wr_buf_val = 1'b1;
    #1;
    check("idle resp_gated", wr_buf_noc0_rdy, 0);
    noc0_wr_buf_val = 1'b0;

    // Single segment, 2 flits.
    exp_q = {mk_hdr(40'h3040, 16'd128, 16'd2), beat_data(16'h1111, 0), beat_data(16'h1111, 1)};
    run_txn("t1_single", 4'h3, 12'h040, 16'd128, 0, 2, 1'b0, 16'h1111, 3, 0);

    // Wraps the end of the buffer: 64 B at 0xFC0, then 128 B at 0x000.
    exp_q = {mk_hdr(40'h3FC0, 16'd64, 16'd1), beat_data(16'h2222, 0),
             mk_hdr(40'h3000, 16'd128, 16'd2), beat_data(16'h2222, 1), beat_data(16'h2222, 2)};
    run_txn("t2_split", 4'h3, 12'hFC0, 16'd192, 0, 3, 1'b0, 16'h2222, 2, 3);

    // Ends exactly at the buffer end: no second header.
    exp_q = {mk_hdr(40'h3F80, 16'd128, 16'd2), beat_data(16'h3333, 0), beat_data(16'h3333, 1)};
    run_txn("t3_exact_fit", 4'h3, 12'hF80, 16'd128, 0, 2, 1'b0, 16'h3333, 3, 0);

    // 70 bytes: second beat carries 6 valid bytes, low 58 zeroed.
    exp_q = {mk_hdr(40'h3100, 16'd70, 16'd2), beat_data(16'h4444, 0),
             pad_zero(beat_data(16'h4444, 1), 58)};
    run_txn("t4_padbytes", 4'h3, 12'h100, 16'd70, 58, 2, 1'b0, 16'h4444, 3, 0);

    // Wrapping write under random backpressure; seg1 = 126 B, final beat pad 2.
    exp_q = {mk_hdr(40'h5FC0, 16'd64, 16'd1), beat_data(16'h5555, 0),
             mk_hdr(40'h5000, 16'd126, 16'd2), beat_data(16'h5555, 1),
             pad_zero(beat_data(16'h5555, 2), 2)};
    run_txn("t5_stall", 4'h5, 12'hFC0, 16'd190, 2, 3, 1'b1, 16'h5555, 2, 3);

    // Reset while streaming data.
    src_wr_buf_req_flowid    = 4'h3;
    src_wr_buf_req_offset    = 12'h000;
    src_wr_buf_req_size      = 16'd128;
    src_wr_buf_req_val       = 1'b1;
    src_wr_buf_data_val      = 1'b1;
    src_wr_buf_data          = beat_data(16'h7777, 0);
    noc0_wr_buf_rdy          = 1'b1;
    #1;
    check("t6 pre_req_rdy", wr_buf_src_req_rdy, 1);
    @(posedge clk); #1;
    src_wr_buf_req_val = 1'b0;
    #1;
    check("t6 hdr_val", wr_buf_noc0_val, 1);
    @(posedge clk); #1;
    check("t6 in_data", wr_buf_src_data_rdy, 1);
    rst = 1'b0;
    #1;
    check("t6 rst noc_val", wr_buf_noc0_val, 0);
    check("t6 rst noc_data", wr_buf_noc0_data, '0);
    check("t6 rst data_rdy", wr_buf_src_data_rdy, 0);
    check("t6 rst req_rdy", wr_buf_src_req_rdy, 0);
    check("t6 rst resp_rdy", wr_buf_noc0_rdy, 0);
    check("t6 rst done_val", wr_buf_src_done_val, 0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6 post_rst req_rdy", wr_buf_src_req_rdy, 1);

    exp_q = {mk_hdr(40'h3040, 16'd128, 16'd2), beat_data(16'h8888, 0), beat_data(16'h8888, 1)};
    run_txn("t7_after_rst", 4'h3, 12'h040, 16'd128, 0, 2, 1'b0, 16'h8888, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
